// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: issues one word-bus transaction per decoded
// load/store, returns the extended load result and flags op/alignment/bus errors.
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        rd_we,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        op_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // size code: 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] op_size(input logic [7:0] o);
    if (o[0] | o[3] | o[5])      return 2'd0;
    else if (o[1] | o[4] | o[6]) return 2'd1;
    else if (o[2] | o[7])        return 2'd2;
    else                         return 2'd0;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic sx, input logic [1:0] sz,
                                              input logic [1:0] a, input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bx;
    logic signed [31:0] hx;
    b  = w[{a, 3'b000} +: 8];
    h  = w[{a[1], 4'b0000} +: 16];
    bx = b;
    hx = h;
    case (sz)
      2'd0:    return sx ? bx : {24'd0, b};
      2'd1:    return sx ? hx : {16'd0, h};
      default: return w;
    endcase
  endfunction

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_p1;
  logic [1:0]       addr_lo_p1;
  logic             sign_p1;
  logic             store_p1;

  logic [1:0] sz_in;
  logic       op_onehot, op_misalign, go_access, tmo_hit;
  logic       misalign_d, op_err_d, bus_err_d, rd_we_d;

  assign busy    = (state != IDLE);
  assign done    = (state == RESP);
  assign mem_req = (state == ACCESS);
  assign mem_we  = mem_req & store_p1;

  always_comb begin
    sz_in       = op_size(op);
    op_onehot   = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    op_misalign = ((sz_in == 2'd2) && (addr[1:0] != 2'b00)) ||
                  ((sz_in == 2'd1) && addr[0]);
    tmo_hit     = (TIMEOUT != 0) && (cnt == CNT_LAST);
    state_d     = state;
    go_access   = 1'b0;
    misalign_d  = 1'b0;
    op_err_d    = 1'b0;
    bus_err_d   = 1'b0;
    rd_we_d     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!op_onehot) begin
            state_d  = RESP;
            op_err_d = 1'b1;
          end else if (op_misalign) begin
            state_d    = RESP;
            misalign_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            go_access = 1'b1;
          end
        end
      end
      ACCESS: begin
        // ack takes priority over a coincident timeout
        if (mem_ack) begin
          state_d = RESP;
          rd_we_d = !store_p1;
        end else if (tmo_hit) begin
          state_d   = RESP;
          bus_err_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // request capture stage: bus fields held stable for the whole access
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      misalign   <= 1'b0;
      op_err     <= 1'b0;
      bus_err    <= 1'b0;
      rd_we      <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      size_p1    <= '0;
      addr_lo_p1 <= '0;
      sign_p1    <= 1'b0;
      store_p1   <= 1'b0;
    end else begin
      misalign <= misalign_d;
      op_err   <= op_err_d;
      bus_err  <= bus_err_d;
      rd_we    <= rd_we_d;
      if (go_access) begin
        cnt        <= '0;
        mem_addr   <= {addr[31:2], 2'b00};
        mem_be     <= lane_be(sz_in, addr[1:0]);
        mem_wdata  <= lane_wdata(sz_in, wdata);
        size_p1    <= sz_in;
        addr_lo_p1 <= addr[1:0];
        sign_p1    <= op[0] | op[1];
        store_p1   <= op[5] | op[6] | op[7];
      end else if ((state == ACCESS) && !mem_ack) begin
        cnt <= cnt + CNT_W'(1);
      end
      // response stage: load lane extracted on the ack edge
      if (rd_we_d) rdata <= load_extend(sign_p1, size_p1, addr_lo_p1, mem_rdata);
    end
  end

endmodule
